softmax_vec_host: RTL and testbench

- Memory-side responder and sequencer for the fixed-point softmax core.
- Buffers one input vector streamed from the host and serves the core's three read ports (max, sub0, sub1) from that buffer.
- Drives init/start/start_addr/end_addr, captures the core's outp0 stream into a result buffer, and streams the results back to the host.
- Sits between the host DMA stream and one softmax core instance.

---
 rtl/softmax_vec_host_pkg.sv | 16 +
 rtl/smx_buf_3r1w.sv | 28 ++
 rtl/softmax_vec_host.sv | 190 +++++++++++++++++++
 tb/tb_softmax_vec_host.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_vec_host_pkg.sv
// Shared constants and FSM encoding for the softmax vector host.
package softmax_vec_host_pkg;
  localparam int SMX_DATAWIDTH = 32;
  localparam int SMX_ADDRSIZE  = 10;
  localparam int SMX_TIMEOUT   = 4096;
  localparam int SMX_NUM_RD    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_START,
    S_RUN,
    S_DRAIN
  } smx_state_e;
endpackage

// File: rtl/smx_buf_3r1w.sv
// Input vector buffer: one write port, NUM_RD asynchronous read ports.
// Reads at or beyond the loaded length return zero.
module smx_buf_3r1w
  import softmax_vec_host_pkg::*;
#(
  parameter int DATAWIDTH = SMX_DATAWIDTH,
  parameter int ADDRSIZE  = SMX_ADDRSIZE,
  parameter int NUM_RD    = SMX_NUM_RD
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [ADDRSIZE-1:0]                 waddr,
  input  logic [DATAWIDTH-1:0]                wdata,
  input  logic [ADDRSIZE:0]                   len,
  input  logic [NUM_RD-1:0][ADDRSIZE-1:0]     raddr,
  output logic [NUM_RD-1:0][DATAWIDTH-1:0]    rdata
);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rdata[i] = ({1'b0, raddr[i]} < len) ? mem[raddr[i]] : '0;
  end
endmodule

// File: rtl/softmax_vec_host.sv
// Host-side sequencer for one softmax core: buffers a vector, runs the core,
// captures results and streams them back. Optional watchdog: SMX_WATCHDOG_EN.
module softmax_vec_host
  import softmax_vec_host_pkg::*;
#(
  parameter int DATAWIDTH = SMX_DATAWIDTH,
  parameter int ADDRSIZE  = SMX_ADDRSIZE,
  parameter int TIMEOUT   = SMX_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 wr_last,
  output logic                 wr_ready,
  output logic                 rd_valid,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_last,
  input  logic                 rd_ready,
  output logic                 busy,
  output logic                 err,
  input  logic [ADDRSIZE-1:0]  core_addr,
  input  logic [ADDRSIZE-1:0]  core_sub0_addr,
  input  logic [ADDRSIZE-1:0]  core_sub1_addr,
  output logic [DATAWIDTH-1:0] core_inp,
  output logic [DATAWIDTH-1:0] core_sub0_inp,
  output logic [DATAWIDTH-1:0] core_sub1_inp,
  output logic [ADDRSIZE-1:0]  core_start_addr,
  output logic [ADDRSIZE-1:0]  core_end_addr,
  output logic                 core_init,
  output logic                 core_start,
  input  logic [DATAWIDTH-1:0] core_outp0,
  input  logic                 core_done
);
  localparam int CW    = ADDRSIZE + 1;
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [CW-1:0] MAXLEN = CW'(DEPTH - 1);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  smx_state_e           state;
  logic [CW-1:0]        wcnt, ccnt, rcnt, len, len_out;
  logic [CW-1:0]        wcnt_inc, ccnt_inc, rcnt_inc;
  logic                 wr_fire;
  logic [DATAWIDTH-1:0] resbuf [DEPTH];

  logic [SMX_NUM_RD-1:0][ADDRSIZE-1:0]  rd_addr;
  logic [SMX_NUM_RD-1:0][DATAWIDTH-1:0] rd_word;

`ifdef SMX_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT);
  logic [WDW-1:0] wd;
`endif

  assign wr_ready        = (state == S_IDLE) || (state == S_LOAD);
  assign busy            = (state != S_IDLE);
  assign wr_fire         = wr_valid && wr_ready;
  assign wcnt_inc        = wcnt + CW'(1);
  assign ccnt_inc        = ccnt + CW'(1);
  assign rcnt_inc        = rcnt + CW'(1);
  assign core_start_addr = '0;

  assign rd_addr       = {core_sub1_addr, core_sub0_addr, core_addr};
  assign core_inp      = rd_word[0];
  assign core_sub0_inp = rd_word[1];
  assign core_sub1_inp = rd_word[2];

  smx_buf_3r1w #(
    .DATAWIDTH(DATAWIDTH),
    .ADDRSIZE (ADDRSIZE),
    .NUM_RD   (SMX_NUM_RD)
  ) u_inbuf (
    .clk  (clk),
    .we   (wr_fire),
    .waddr(wcnt[ADDRSIZE-1:0]),
    .wdata(wr_data),
    .len  (len),
    .raddr(rd_addr),
    .rdata(rd_word)
  );

  always_ff @(posedge clk)
    if (state == S_RUN && core_done) resbuf[ccnt[ADDRSIZE-1:0]] <= core_outp0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      wcnt          <= '0;
      ccnt          <= '0;
      rcnt          <= '0;
      len           <= '0;
      len_out       <= '0;
      err           <= 1'b0;
      core_init     <= 1'b0;
      core_start    <= 1'b0;
      core_end_addr <= '0;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
      rd_data       <= '0;
`ifdef SMX_WATCHDOG_EN
      wd            <= '0;
`endif
    end else begin
      core_init  <= 1'b0;
      core_start <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (wr_fire) begin
            wcnt <= wcnt_inc;
            if (state == S_IDLE) err <= 1'b0;
            // A full buffer without wr_last is closed off as if it were last.
            if (wr_last || wcnt_inc == MAXLEN) begin
              len           <= wcnt_inc;
              core_end_addr <= wcnt_inc[ADDRSIZE-1:0];
              core_init     <= 1'b1;
              state         <= S_INIT;
              if (!wr_last) err <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_INIT: begin
          core_start <= 1'b1;
          state      <= S_START;
        end
        S_START: begin
          ccnt  <= '0;
          state <= S_RUN;
`ifdef SMX_WATCHDOG_EN
          wd    <= '0;
`endif
        end
        S_RUN: begin
          if (core_done) begin
            ccnt <= ccnt_inc;
`ifdef SMX_WATCHDOG_EN
            wd   <= '0;
`endif
            if (ccnt_inc == len) begin
              len_out <= len;
              rcnt    <= '0;
              state   <= S_DRAIN;
            end
          end else if (ccnt != '0) begin
            err     <= 1'b1;
            len_out <= ccnt;
            rcnt    <= '0;
            state   <= S_DRAIN;
          end
`ifdef SMX_WATCHDOG_EN
          // Only reachable with nothing captured; a gap after a capture ends RUN above.
          else if (wd == WDW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            wcnt  <= '0;
            ccnt  <= '0;
            rcnt  <= '0;
            state <= S_IDLE;
          end else begin
            wd <= wd + WDW'(1);
          end
`endif
        end
        S_DRAIN: begin
          if (!rd_valid) begin
            rd_data  <= resbuf[rcnt[ADDRSIZE-1:0]];
            rd_last  <= (rcnt == len_out - CW'(1));
            rd_valid <= 1'b1;
          end else if (rd_ready) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              wcnt     <= '0;
              ccnt     <= '0;
              rcnt     <= '0;
              state    <= S_IDLE;
            end else begin
              rcnt    <= rcnt_inc;
              rd_data <= resbuf[rcnt_inc[ADDRSIZE-1:0]];
              rd_last <= (rcnt_inc == len_out - CW'(1));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_vec_host.sv
// Randomized bench for softmax_vec_host with a queue-based reference model.
module tb_softmax_vec_host;
  localparam int DW     = 32;
  localparam int AW     = 3;
  localparam int TO     = 16;
  localparam int MAXLEN = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0, wr_last = 1'b0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid, rd_last, rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          busy, err;
  logic [AW-1:0] core_addr = '0, core_sub0_addr = '0, core_sub1_addr = '0;
  logic [DW-1:0] core_inp, core_sub0_inp, core_sub1_inp;
  logic [AW-1:0] core_start_addr, core_end_addr;
  logic          core_init, core_start;
  logic [DW-1:0] core_outp0 = '0;
  logic          core_done = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] model_mem [MAXLEN+1];
  int model_len = 0;

  softmax_vec_host #(.DATAWIDTH(DW), .ADDRSIZE(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .busy(busy), .err(err),
    .core_addr(core_addr), .core_sub0_addr(core_sub0_addr), .core_sub1_addr(core_sub1_addr),
    .core_inp(core_inp), .core_sub0_inp(core_sub0_inp), .core_sub1_inp(core_sub1_inp),
    .core_start_addr(core_start_addr), .core_end_addr(core_end_addr),
    .core_init(core_init), .core_start(core_start),
    .core_outp0(core_outp0), .core_done(core_done)
  );

  always #10 clk = ~clk;

  function automatic logic [DW-1:0] ref_rd(input int a);
    return (a < model_len) ? model_mem[a] : '0;
  endfunction

  task automatic send_beats(input logic [DW-1:0] vin[$], input bit with_last, output int acc);
    bit stalled = 1'b0;
    acc = 0;
    foreach (vin[i]) begin
      @(negedge clk);
      if (!wr_ready) begin stalled = 1'b1; break; end
      wr_valid = 1'b1;
      wr_data  = vin[i];
      wr_last  = with_last && (i == vin.size() - 1);
      acc++;
    end
    if (!stalled) @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Full load / run / drain pass; the model core returns ndone random results.
  task automatic run_vector(input string tag, input logic [DW-1:0] vin[$], input bit with_last,
                            input int ndone, input int bp_mode, input int pre_wait);
    int acc, exp_len, exp_n, beats, hold;
    bit exp_err, prev_hold, got_last;
    logic [DW-1:0] res[$];
    logic [DW-1:0] prev_data, v;

    exp_len = (vin.size() < MAXLEN) ? vin.size() : MAXLEN;
    exp_err = !with_last || (vin.size() > MAXLEN);
    model_len = exp_len;
    for (int i = 0; i < exp_len; i++) model_mem[i] = vin[i];

    send_beats(vin, with_last, acc);
    n_cmp++;
    if (acc !== exp_len) begin n_fail++; $display("FAIL %s accepted: got %0d want %0d", tag, acc, exp_len); end
    n_cmp++;
    if ({core_init, core_start, wr_ready, busy} !== 4'b1001) begin
      n_fail++; $display("FAIL %s init_pulse: init/start/wr_ready/busy got %b want 1001", tag, {core_init, core_start, wr_ready, busy});
    end
    n_cmp++;
    if (core_end_addr !== AW'(exp_len) || core_start_addr !== '0) begin
      n_fail++; $display("FAIL %s bounds: got %0d..%0d want 0..%0d", tag, core_start_addr, core_end_addr, exp_len);
    end
    n_cmp++;
    if (err !== exp_err) begin n_fail++; $display("FAIL %s load_err: got %b want %b", tag, err, exp_err); end

    for (int a = 0; a <= MAXLEN; a++) begin
      core_addr = AW'(a); core_sub0_addr = AW'(MAXLEN - a); core_sub1_addr = AW'(a + 3);
      #1;
      n_cmp++;
      if (core_inp !== ref_rd(a) || core_sub0_inp !== ref_rd(MAXLEN - a) || core_sub1_inp !== ref_rd((a + 3) % (MAXLEN + 1))) begin
        n_fail++;
        $display("FAIL %s core_read a=%0d: got %h %h %h want %h %h %h", tag, a, core_inp, core_sub0_inp, core_sub1_inp,
                 ref_rd(a), ref_rd(MAXLEN - a), ref_rd((a + 3) % (MAXLEN + 1)));
      end
    end

    @(negedge clk);
    n_cmp++;
    if ({core_init, core_start} !== 2'b01) begin
      n_fail++; $display("FAIL %s start_pulse: init/start got %b want 01", tag, {core_init, core_start});
    end
    @(negedge clk);
    repeat (pre_wait) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s run_wait: busy/rd_valid got %b%b want 10", tag, busy, rd_valid);
    end

    for (int k = 0; k < ndone; k++) begin
      v = $urandom;
      core_done = 1'b1; core_outp0 = v;
      if (k < exp_len) res.push_back(v);
      @(negedge clk);
    end
    core_done = 1'b0; core_outp0 = '0;
    exp_n = res.size();
    if (ndone < exp_len) exp_err = 1'b1;

    beats = 0; hold = 0; prev_hold = 1'b0; got_last = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200 && !got_last; cyc++) begin
      @(negedge clk);
      if (prev_hold && rd_valid) begin
        n_cmp++;
        if (rd_data !== prev_data) begin n_fail++; $display("FAIL %s rd_hold: got %h want %h", tag, rd_data, prev_data); end
      end
      if (bp_mode == 0) rd_ready = 1'b1;
      else if (bp_mode == 1) begin
        rd_ready = !(beats == 1 && hold < 3);
        if (!rd_ready) hold++;
      end else rd_ready = 1'($urandom_range(0, 1));
      if (rd_valid && rd_ready) begin
        n_cmp++;
        if (beats >= exp_n) begin
          n_fail++; $display("FAIL %s rd_extra: got beat %0d want at most %0d beats", tag, beats + 1, exp_n);
        end else if (rd_data !== res[beats] || rd_last !== (beats == exp_n - 1)) begin
          n_fail++; $display("FAIL %s rd_beat %0d: got %h last=%b want %h last=%b", tag, beats, rd_data, rd_last,
                             res[beats], (beats == exp_n - 1));
        end
        got_last = rd_last;
        beats++;
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
    end
    @(negedge clk);
    rd_ready = 1'b0;
    n_cmp++;
    if (beats !== exp_n) begin n_fail++; $display("FAIL %s rd_count: got %0d want %0d", tag, beats, exp_n); end
    n_cmp++;
    if ({busy, rd_valid, wr_ready} !== 3'b001) begin
      n_fail++; $display("FAIL %s idle_after: busy/rd_valid/wr_ready got %b want 001", tag, {busy, rd_valid, wr_ready});
    end
    n_cmp++;
    if (err !== exp_err) begin n_fail++; $display("FAIL %s final_err: got %b want %b", tag, err, exp_err); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    core_addr = 3'd2; core_sub0_addr = 3'd0; core_sub1_addr = 3'd5;
    #1;
    n_cmp++;
    if ({wr_ready, rd_valid, rd_last, busy, err, core_init, core_start} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 1000000", {wr_ready, rd_valid, rd_last, busy, err, core_init, core_start});
    end
    n_cmp++;
    if (core_start_addr !== '0 || core_end_addr !== '0) begin
      n_fail++; $display("FAIL reset_bounds: got %0d %0d want 0 0", core_start_addr, core_end_addr);
    end
    n_cmp++;
    if (core_inp !== '0 || core_sub0_inp !== '0 || core_sub1_inp !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h %h want 0", core_inp, core_sub0_inp, core_sub1_inp);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] q[$];
    q = '{32'd5, 32'd3, 32'd9, 32'd1};
    run_vector("basic", q, 1'b1, 4, 0, 0);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] q[$];
    for (int i = 0; i < 5; i++) q.push_back($urandom);
    run_vector("backpressure", q, 1'b1, 5, 1, 1);
  endtask

  task automatic test_overflow();
    logic [DW-1:0] q[$];
    for (int i = 0; i < 10; i++) q.push_back($urandom);
    run_vector("overflow", q, 1'b0, MAXLEN, 0, 0);
  endtask

  task automatic test_short();
    logic [DW-1:0] q[$];
    for (int i = 0; i < 5; i++) q.push_back($urandom);
    run_vector("short", q, 1'b1, 3, 0, 2);
  endtask

  task automatic test_extra_done();
    logic [DW-1:0] q[$];
    for (int i = 0; i < 3; i++) q.push_back($urandom);
    run_vector("extra_done", q, 1'b1, 5, 2, 0);
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    int n;
    for (int it = 0; it < 8; it++) begin
      n = (it == 0) ? 1 : (it == 1) ? MAXLEN : int'($urandom_range(1, MAXLEN));
      q.delete();
      for (int i = 0; i < n; i++) q.push_back($urandom);
      run_vector("random", q, 1'b1, n, 2, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_run();
    logic [DW-1:0] q[$];
    int acc;
    q = '{32'h11, 32'h22, 32'h33};
    send_beats(q, 1'b1, acc);
    @(negedge clk);
    @(negedge clk);
    core_done = 1'b1; core_outp0 = 32'hABCD;
    @(negedge clk);
    core_done = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    core_addr = 3'd1;
    #1;
    n_cmp++;
    if ({busy, wr_ready, rd_valid, err} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_run_state: busy/wr_ready/rd_valid/err got %b want 0100", {busy, wr_ready, rd_valid, err});
    end
    n_cmp++;
    if (core_end_addr !== '0 || core_inp !== '0) begin
      n_fail++; $display("FAIL reset_run_regs: end_addr=%0d inp=%h want 0 0", core_end_addr, core_inp);
    end
    q = '{$urandom, $urandom};
    run_vector("after_reset", q, 1'b1, 2, 0, 0);
  endtask

`ifdef SMX_WATCHDOG_EN
  task automatic test_watchdog();
    logic [DW-1:0] q[$];
    int acc, k;
    bit saw_rd = 1'b0;
    q = '{32'd1, 32'd2, 32'd3};
    send_beats(q, 1'b1, acc);
    @(negedge clk);
    n_cmp++;
    if (core_start !== 1'b1) begin n_fail++; $display("FAIL wd_start: got %b want 1", core_start); end
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rd_valid) saw_rd = 1'b1;
      if (!busy) break;
    end
    n_cmp++;
    if (k < TO || k > TO + 1) begin n_fail++; $display("FAIL wd_cycles: got %0d want %0d..%0d", k, TO, TO + 1); end
    n_cmp++;
    if (err !== 1'b1 || saw_rd !== 1'b0) begin
      n_fail++; $display("FAIL wd_result: err=%b saw_rd=%b want err=1 saw_rd=0", err, saw_rd);
    end
  endtask
`else
  task automatic test_no_watchdog();
    logic [DW-1:0] q[$];
    q = '{$urandom, $urandom, $urandom};
    run_vector("long_wait", q, 1'b1, 3, 0, 40);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_short();
    test_extra_done();
    test_random();
    test_reset_run();
`ifdef SMX_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
